// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forwarding control for a 5-stage in-order pipeline
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MD_LAT   = 4,
  parameter int STALL_CW = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [REG_AW-1:0]   id_dst,
  input  logic                id_regw,
  input  logic                id_memr,
  input  logic                id_md,
  input  logic                redirect,
  output logic                pc_we,
  output logic                ifid_we,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                fwd_c,
  output logic                fwd_d,
  output logic                md_busy,
  output logic [STALL_CW-1:0] stall_count
);

  localparam logic [3:0] MdInit = 4'(MD_LAT - 1);

  logic                exValid, exRegw, exMemr, exMd;
  logic [REG_AW-1:0]   exDst, exRs, exRt;
  logic                memValid, memRegw;
  logic [REG_AW-1:0]   memDst;
  logic                wbValid, wbRegw;
  logic [REG_AW-1:0]   wbDst;
  logic [3:0]          busyCnt;
  logic [STALL_CW-1:0] stallCnt;
  logic                mdBusy, loadUse;

  function automatic logic hit(input logic v, input logic w,
                               input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s);
    return v && w && (d != '0) && (d == s);
  endfunction

  assign mdBusy  = exValid && exMd && (busyCnt != 4'd0);
  assign loadUse = exValid && exMemr && exRegw && (exDst != '0) &&
                   ((id_use_rs && (id_rs == exDst)) || (id_use_rt && (id_rt == exDst)));

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    // Held in the idle pattern while reset is low, whatever the ID inputs say.
    if (Reset_n) begin
      if (redirect) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (mdBusy) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        exmem_flush = 1'b1;
      end else if (loadUse) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  assign fwd_a = hit(memValid, memRegw, memDst, exRs) ? 2'd2 :
                 hit(wbValid, wbRegw, wbDst, exRs)    ? 2'd1 : 2'd0;
  assign fwd_b = hit(memValid, memRegw, memDst, exRt) ? 2'd2 :
                 hit(wbValid, wbRegw, wbDst, exRt)    ? 2'd1 : 2'd0;
  assign fwd_c = hit(wbValid, wbRegw, wbDst, id_rs);
  assign fwd_d = hit(wbValid, wbRegw, wbDst, id_rt);
  assign md_busy     = mdBusy;
  assign stall_count = stallCnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      exValid  <= 1'b0; exRegw <= 1'b0; exMemr <= 1'b0; exMd <= 1'b0;
      exDst    <= '0;   exRs   <= '0;   exRt   <= '0;
      memValid <= 1'b0; memRegw <= 1'b0; memDst <= '0;
      wbValid  <= 1'b0; wbRegw  <= 1'b0; wbDst  <= '0;
      busyCnt  <= 4'd0;
      stallCnt <= '0;
    end else begin
      if (!pc_we && (stallCnt != '1))
        stallCnt <= stallCnt + 1'b1;

      if (redirect) begin
        exValid  <= 1'b0; exRegw <= 1'b0; exMemr <= 1'b0; exMd <= 1'b0;
        exDst    <= '0;   exRs   <= '0;   exRt   <= '0;
        memValid <= 1'b0; memRegw <= 1'b0; memDst <= '0;
        wbValid  <= memValid; wbRegw <= memRegw; wbDst <= memDst;
        busyCnt  <= 4'd0;
      end else if (mdBusy) begin
        // EX holds the multi-cycle op; a bubble drains into MEM behind it.
        memValid <= 1'b0; memRegw <= 1'b0; memDst <= '0;
        wbValid  <= memValid; wbRegw <= memRegw; wbDst <= memDst;
        busyCnt  <= busyCnt - 4'd1;
      end else begin
        wbValid  <= memValid; wbRegw  <= memRegw; wbDst  <= memDst;
        memValid <= exValid;  memRegw <= exRegw;  memDst <= exDst;
        if (loadUse) begin
          exValid <= 1'b0; exRegw <= 1'b0; exMemr <= 1'b0; exMd <= 1'b0;
          exDst   <= '0;   exRs   <= '0;   exRt   <= '0;
          busyCnt <= 4'd0;
        end else begin
          exValid <= 1'b1;      exRegw <= id_regw; exMemr <= id_memr; exMd <= id_md;
          exDst   <= id_dst;    exRs   <= id_rs;   exRt   <= id_rt;
          busyCnt <= id_md ? MdInit : 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_regw = 1'b0, id_memr = 1'b0, id_md = 1'b0;
  logic       redirect = 1'b0;

  logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, fwd_c, fwd_d, md_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  logic        s2PcWe, s2IfidWe, s2IfidFlush, s2IdexFlush, s2ExmemFlush, s2FwdC, s2FwdD, s2MdBusy;
  logic [1:0]  s2FwdA, s2FwdB;
  logic [1:0]  s2StallCount;

  pipe_hazard_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regw(id_regw), .id_memr(id_memr), .id_md(id_md), .redirect(redirect),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.STALL_CW(2)) dutSmall (
    .Clk(Clk), .Reset_n(Reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regw(id_regw), .id_memr(id_memr), .id_md(id_md), .redirect(redirect),
    .pc_we(s2PcWe), .ifid_we(s2IfidWe), .ifid_flush(s2IfidFlush), .idex_flush(s2IdexFlush),
    .exmem_flush(s2ExmemFlush), .fwd_a(s2FwdA), .fwd_b(s2FwdB), .fwd_c(s2FwdC), .fwd_d(s2FwdD),
    .md_busy(s2MdBusy), .stall_count(s2StallCount)
  );

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       regw, memr, md;
  } instr_t;

  typedef struct packed {
    logic [12:0] v;
    logic [15:0] st;
    logic [1:0]  sts;
  } res_t;

  res_t expQ[$];
  res_t obsQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic instr_t ins(input logic [4:0] rs, rt, input logic urs, urt,
                                 input logic [4:0] dst, input logic regw, memr, md);
    return {rs, rt, urs, urt, dst, regw, memr, md};
  endfunction

  // {pc_we, ifid_we, ifid/idex/exmem flush, fwd_a, fwd_b, fwd_c, fwd_d, md_busy}
  function automatic logic [12:0] ev(input logic stall, input logic [2:0] fl,
                                     input logic [1:0] fa, fb, input logic fc, fd, busy);
    return {~stall, ~stall, fl, fa, fb, fc, fd, busy};
  endfunction

  function automatic res_t sample();
    return {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
            fwd_c, fwd_d, md_busy, stall_count, s2StallCount};
  endfunction

  localparam instr_t NOP = '0;
  instr_t LW5, ADD655, MULT, ADD9, ADD3, ADD4, ADD7, OR8, LW0, ADD600;
  logic [12:0] NORM, BUSY, LU, RDR;

  task automatic drive(input instr_t i, input logic redir, input logic [12:0] e, input logic [15:0] est);
    @(negedge Clk);
    {id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regw, id_memr, id_md} = i;
    redirect = redir;
    expQ.push_back({e, est, (est > 16'd3) ? 2'd3 : est[1:0]});
    #4;
    obsQ.push_back(sample());
  endtask

  task automatic rst_pulse();
    @(negedge Clk);
    Reset_n = 1'b0;
    {id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regw, id_memr, id_md} = NOP;
    redirect = 1'b0;
    #2 Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    res_t e, o;
    int n = 0;
    Reset_n = 1'b0;
    drive(LW5, 1'b1, NORM, 16'd0);
    drive(MULT, 1'b0, NORM, 16'd0);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  task automatic test_forward();
    res_t e, o;
    int n = 0;
    rst_pulse();
    drive(ADD3, 1'b0, NORM, 16'd0);
    drive(ADD4, 1'b0, NORM, 16'd0);
    drive(ADD7, 1'b0, ev(0, 3'b000, 2'd2, 2'd0, 0, 0, 0), 16'd0);
    drive(OR8,  1'b0, ev(0, 3'b000, 2'd1, 2'd0, 1, 0, 0), 16'd0);
    drive(NOP,  1'b0, ev(0, 3'b000, 2'd0, 2'd1, 0, 0, 0), 16'd0);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL forward c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  task automatic test_load_use();
    res_t e, o;
    int n = 0;
    rst_pulse();
    drive(LW5,    1'b0, NORM, 16'd0);
    drive(ADD655, 1'b0, LU,   16'd0);
    drive(ADD655, 1'b0, NORM, 16'd1);
    drive(NOP,    1'b0, ev(0, 3'b000, 2'd1, 2'd1, 0, 0, 0), 16'd1);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load_use c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  task automatic test_multi_cycle();
    res_t e, o;
    int n = 0;
    rst_pulse();
    drive(MULT, 1'b0, NORM, 16'd0);
    drive(ADD9, 1'b0, BUSY, 16'd0);
    drive(ADD9, 1'b0, BUSY, 16'd1);
    drive(ADD9, 1'b0, BUSY, 16'd2);
    drive(ADD9, 1'b0, NORM, 16'd3);
    drive(NOP,  1'b0, NORM, 16'd3);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL multi_cycle c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  task automatic test_redirect();
    res_t e, o;
    int n = 0;
    rst_pulse();
    drive(MULT,   1'b0, NORM, 16'd0);
    drive(NOP,    1'b1, RDR | 13'd1, 16'd0);
    drive(NOP,    1'b0, NORM, 16'd0);
    drive(LW5,    1'b0, NORM, 16'd0);
    drive(ADD655, 1'b1, RDR,  16'd0);
    drive(ADD655, 1'b0, NORM, 16'd0);
    drive(NOP,    1'b0, NORM, 16'd0);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL redirect c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  task automatic test_reg_zero();
    res_t e, o;
    int n = 0;
    rst_pulse();
    drive(LW0,    1'b0, NORM, 16'd0);
    drive(ADD600, 1'b0, NORM, 16'd0);
    drive(ADD600, 1'b0, NORM, 16'd0);
    drive(ADD600, 1'b0, NORM, 16'd0);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reg_zero c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  task automatic test_saturate_async_reset();
    res_t e, o;
    int n = 0;
    rst_pulse();
    drive(MULT,   1'b0, NORM, 16'd0);
    drive(NOP,    1'b0, BUSY, 16'd0);
    drive(NOP,    1'b0, BUSY, 16'd1);
    drive(NOP,    1'b0, BUSY, 16'd2);
    drive(LW5,    1'b0, NORM, 16'd3);
    drive(ADD655, 1'b0, LU,   16'd3);
    drive(LW5,    1'b0, NORM, 16'd4);
    drive(ADD655, 1'b0, ev(1, 3'b010, 2'd0, 2'd0, 1, 1, 0), 16'd4);
    drive(MULT,   1'b0, NORM, 16'd5);
    drive(NOP,    1'b0, BUSY, 16'd5);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    expQ.push_back({NORM, 16'd0, 2'd0});
    obsQ.push_back(sample());
    #1 Reset_n = 1'b1;
    drive(NOP, 1'b0, NORM, 16'd0);
    drive(NOP, 1'b0, NORM, 16'd0);
    while (expQ.size() != 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL saturate c%0d: got ctl=%b st=%0d/%0d want ctl=%b st=%0d/%0d", n, o.v, o.st, o.sts, e.v, e.st, e.sts);
      end
      n++;
    end
  endtask

  initial begin
    LW5    = ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    ADD655 = ins(5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0);
    MULT   = ins(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1);
    ADD9   = ins(5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0);
    ADD3   = ins(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    ADD4   = ins(5'd3, 5'd1, 1, 1, 5'd4, 1, 0, 0);
    ADD7   = ins(5'd3, 5'd0, 1, 1, 5'd7, 1, 0, 0);
    OR8    = ins(5'd3, 5'd4, 1, 1, 5'd8, 1, 0, 0);
    LW0    = ins(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0);
    ADD600 = ins(5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0);
    NORM   = ev(0, 3'b000, 2'd0, 2'd0, 0, 0, 0);
    BUSY   = ev(1, 3'b001, 2'd0, 2'd0, 0, 0, 1);
    LU     = ev(1, 3'b010, 2'd0, 2'd0, 0, 0, 0);
    RDR    = ev(0, 3'b111, 2'd0, 2'd0, 0, 0, 0);

    test_reset();
    test_forward();
    test_load_use();
    test_multi_cycle();
    test_redirect();
    test_reg_zero();
    test_saturate_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
